i_softmax: RTL and testbench

Streaming integer-only softmax unit (I-BERT style) for the quantized attention path. It tracks a running signed maximum and a running sum of integer exponentials. For each accumulated element it outputs that element's fixed-point probability relative to the elements accumulated so far. The exponential uses the shift-plus-second-order-polynomial approximation driven by runtime quantized constants.

---
 rtl/i_softmax_pkg.sv | 13 +
 rtl/i_softmax_if.sv | 27 ++
 rtl/i_exp.sv | 43 ++++
 rtl/i_softmax.sv | 71 +++++++
 tb/tb_i_softmax.sv | 126 ++++++++++++
 5 files changed

// File: rtl/i_softmax_pkg.sv
// Shared constants and helpers for the streaming integer softmax unit.
package i_softmax_pkg;

  localparam int DEF_INV_FRAC = 11;
  localparam int DEF_OUT_FRAC = 8;
  localparam logic [31:0] MAX_RESET = 32'h8000_0000;
  localparam int SUM_W = 48;

  function automatic logic [31:0] sat32(input logic [63:0] v);
    return (|v[63:32]) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

endpackage

// File: rtl/i_softmax_if.sv
// Data/control bundle for i_softmax; the debug signals expose the running max and sum.
interface i_softmax_if;
  import i_softmax_pkg::*;

  logic signed [31:0] q_in_soft;
  logic signed [31:0] q_b;
  logic signed [31:0] q_c;
  logic [31:0]        q_ln2;
  logic [31:0]        q_ln2_neg_inv;
  logic               EN_max;
  logic               EN_acc;
  logic [31:0]        q_out_soft;
  logic [31:0]        dbg_max;
  logic [SUM_W-1:0]   dbg_sum;

  // No handshake: inputs are sampled only on rising edges where EN_max or EN_acc is high.
  modport master (
    output q_in_soft, q_b, q_c, q_ln2, q_ln2_neg_inv, EN_max, EN_acc,
    input  q_out_soft, dbg_max, dbg_sum
  );

  modport slave (
    input  q_in_soft, q_b, q_c, q_ln2, q_ln2_neg_inv, EN_max, EN_acc,
    output q_out_soft, dbg_max, dbg_sum
  );

endinterface

// File: rtl/i_exp.sv
// Combinational integer exponential: shift by multiples of ln2 plus a second-order polynomial.
module i_exp
  import i_softmax_pkg::*;
#(
  parameter int INV_FRAC = DEF_INV_FRAC
) (
  input  logic signed [31:0] x_i,
  input  logic signed [31:0] q_b_i,
  input  logic signed [31:0] q_c_i,
  input  logic [31:0]        q_ln2_i,
  input  logic [31:0]        q_ln2_neg_inv_i,
  output logic [31:0]        e_o
);

  logic [32:0] a;
  logic [63:0] prod;
  logic [63:0] z;
  logic [63:0] x_ext;
  logic [63:0] b_ext;
  logic [63:0] c_ext;
  logic [63:0] p;
  logic [63:0] base;
  logic [63:0] l_raw;
  logic [63:0] l_pos;
  logic [63:0] shifted;

  // Two's-complement wraparound makes unsigned 64-bit arithmetic equal to the signed result.
  always_comb begin
    a       = 33'd0 - {x_i[31], x_i};
    prod    = {31'd0, a} * {32'd0, q_ln2_neg_inv_i};
    z       = prod >> INV_FRAC;
    x_ext   = {{32{x_i[31]}}, x_i};
    b_ext   = {{32{q_b_i[31]}}, q_b_i};
    c_ext   = {{32{q_c_i[31]}}, q_c_i};
    p       = x_ext + z * {32'd0, q_ln2_i};
    base    = p + b_ext;
    l_raw   = base * base + c_ext;
    l_pos   = l_raw[63] ? 64'd0 : l_raw;
    shifted = (z >= 64'd64) ? 64'd0 : (l_pos >> z[5:0]);
    e_o     = sat32(shifted);
  end

endmodule

// File: rtl/i_softmax.sv
// Streaming softmax: running signed max, saturating sum of exponentials, registered probability.
module i_softmax
  import i_softmax_pkg::*;
#(
  parameter int INV_FRAC = DEF_INV_FRAC,
  parameter int OUT_FRAC = DEF_OUT_FRAC
) (
  input logic  CLK,
  input logic  RST_n,
  i_softmax_if.slave sm
);

  logic signed [31:0] max_q, max_d, m_eff;
  logic [SUM_W-1:0]   sum_q, sum_d, s;
  logic [31:0]        out_q, out_d;
  logic [32:0]        diff;
  logic signed [31:0] x;
  logic [31:0]        e;
  logic [SUM_W:0]     sum_ext;
  logic [63:0]        num, den, quot;

  // When both enables are set the exponential is taken against the updated max.
  always_comb begin
    m_eff = (sm.EN_max && (sm.q_in_soft > max_q)) ? sm.q_in_soft : max_q;
    max_d = sm.EN_max ? m_eff : max_q;
    diff  = {sm.q_in_soft[31], sm.q_in_soft} - {m_eff[31], m_eff};
    if (!diff[32]) begin
      x = 32'sd0;
    end else if (!diff[31]) begin
      x = 32'sh8000_0000;
    end else begin
      x = diff[31:0];
    end
  end

  i_exp #(.INV_FRAC(INV_FRAC)) u_exp (
    .x_i            (x),
    .q_b_i          (sm.q_b),
    .q_c_i          (sm.q_c),
    .q_ln2_i        (sm.q_ln2),
    .q_ln2_neg_inv_i(sm.q_ln2_neg_inv),
    .e_o            (e)
  );

  always_comb begin
    sum_ext = {1'b0, sum_q} + {{(SUM_W - 31){1'b0}}, e};
    s       = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
    num     = {32'd0, e} << OUT_FRAC;
    den     = {{(64 - SUM_W){1'b0}}, s};
    quot    = (s == '0) ? 64'd0 : num / den;
    sum_d   = sm.EN_acc ? s : sum_q;
    out_d   = sm.EN_acc ? sat32(quot) : out_q;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      max_q <= MAX_RESET;
      sum_q <= '0;
      out_q <= '0;
    end else begin
      max_q <= max_d;
      sum_q <= sum_d;
      out_q <= out_d;
    end
  end

  assign sm.q_out_soft = out_q;
  assign sm.dbg_max    = max_q;
  assign sm.dbg_sum    = sum_q;

endmodule

// File: tb/tb_i_softmax.sv
// Directed bench for i_softmax with hand-computed expected probabilities, maxima and sums.
module tb_i_softmax;
  import i_softmax_pkg::*;

  logic CLK;
  logic RST_n;
  int   tests;
  int   fails;

  i_softmax_if sm_if ();

  i_softmax dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .sm   (sm_if.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] v, input logic en_m, input logic en_a);
    @(negedge CLK);
    sm_if.q_in_soft = v;
    sm_if.EN_max    = en_m;
    sm_if.EN_acc    = en_a;
    @(posedge CLK);
    #1;
    sm_if.EN_max = 1'b0;
    sm_if.EN_acc = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_n = 1'b0;
    @(negedge CLK);
    RST_n = 1'b1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_out,
                             input logic [31:0] e_max, input logic [47:0] e_sum);
    check({tag, "_out"}, {32'd0, sm_if.q_out_soft}, {32'd0, e_out});
    check({tag, "_max"}, {32'd0, sm_if.dbg_max}, {32'd0, e_max});
    check({tag, "_sum"}, {16'd0, sm_if.dbg_sum}, {16'd0, e_sum});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RST_n = 1'b0;
    sm_if.q_in_soft     = 32'd0;
    sm_if.q_b           = 32'sd1;
    sm_if.q_c           = 32'sd1;
    sm_if.q_ln2         = 32'd32;
    sm_if.q_ln2_neg_inv = 32'd64;
    sm_if.EN_max        = 1'b0;
    sm_if.EN_acc        = 1'b0;

    // Enables pulsed while reset is held must be ignored.
    step(32'd10, 1'b1, 1'b1);
    step(32'd20, 1'b1, 1'b1);
    step(32'd30, 1'b1, 1'b1);
    check_state("rst_hold", 32'd0, 32'h8000_0000, 48'd0);

    @(negedge CLK);
    RST_n = 1'b1;

    step(32'd10, 1'b1, 1'b0);
    check_state("max10", 32'd0, 32'd10, 48'd0);
    step(32'd10, 1'b0, 1'b1);
    check_state("acc10", 32'd256, 32'd10, 48'd2);
    step(32'd20, 1'b1, 1'b1);
    check_state("both20", 32'd128, 32'd20, 48'd4);
    step(-32'sd10, 1'b0, 1'b1);
    check_state("accm10", 32'd254, 32'd20, 48'd846);
    step(-32'sd44, 1'b0, 1'b1);
    check_state("shift64", 32'd0, 32'd20, 48'd846);

    // Output of the last accumulated element holds through idle cycles.
    step(32'd999, 1'b0, 1'b0);
    check_state("idle", 32'd0, 32'd20, 48'd846);

    step(32'h7FFF_FFFF, 1'b1, 1'b0);
    check_state("max_hi", 32'd0, 32'h7FFF_FFFF, 48'd846);
    step(-32'sd20, 1'b0, 1'b1);
    check_state("clamp", 32'd0, 32'h7FFF_FFFF, 48'd846);

    do_reset();
    check_state("reset2", 32'd0, 32'h8000_0000, 48'd0);
    step(32'd70, 1'b1, 1'b1);
    check_state("both70", 32'd256, 32'd70, 48'd2);
    step(32'd38, 1'b0, 1'b1);
    check_state("z1", 32'd85, 32'd70, 48'd3);

    // Asynchronous reset between clock edges.
    @(negedge CLK);
    #2;
    RST_n = 1'b0;
    #1;
    check_state("async_rst", 32'd0, 32'h8000_0000, 48'd0);
    @(negedge CLK);
    RST_n = 1'b1;

    step(32'd5, 1'b0, 1'b1);
    check_state("above_max", 32'd256, 32'h8000_0000, 48'd2);

    do_reset();
    sm_if.q_b = 32'sd0;
    sm_if.q_c = -32'sd5;
    step(32'd5, 1'b1, 1'b1);
    check_state("neg_l", 32'd0, 32'd5, 48'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
